// File: rtl/sfp_tx_send_scheduler.sv
// sfp_tx_send_scheduler
//  Periodic round-robin scheduler for the two send_packet controllers that
//  feed the TSE MACs. Every PERIOD cycles of good link it latches the channel
//  enables, then serves each enabled channel in turn: a CMD_PULSE-long
//  cmd_send pulse with the shared RAM start address, then a bounded wait for
//  that channel's busy to drop. Link loss aborts the round at once.
//  Optional build macro SCHED_STATS_EN adds per-channel completed-send
//  counters (send_cnt_1_o / send_cnt_2_o).
module sfp_tx_send_scheduler #(
    parameter int unsigned       PERIOD     = 32'h05F5E100,
    parameter int unsigned       CMD_PULSE  = 3,
    parameter int unsigned       TIMEOUT    = 1_000_000,
    parameter int unsigned       ADDR_W     = 25,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(1)
) (
    input  logic              clk_50_pll,
    input  logic              main_reset,
    input  logic              link_ok_i,
    input  logic [1:0]        ch_en_i,
    input  logic [1:0]        busy_i,
    output logic [ADDR_W-1:0] start_ram_addr_o,
    output logic [1:0]        cmd_send_o,
    output logic              active_ch_o,
    output logic              round_done_o,
    output logic [1:0]        timeout_o
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]       send_cnt_1_o,
    output logic [15:0]       send_cnt_2_o
`endif
);

    localparam int PW = (CMD_PULSE > 1) ? $clog2(CMD_PULSE) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0]   TIMER_LAST = 32'(PERIOD - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(CMD_PULSE - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_PERIOD,
        ISSUE,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t              state_q;
    logic [31:0]         timer_q;
    logic                link_seen_q;   // link_ok_i from the previous cycle
    logic [1:0]          mask_q;        // enabled channels not yet served this round
    logic                ch_q;
    logic [PW-1:0]       pulse_q;
    logic [WW-1:0]       wait_q;
    logic [1:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                round_done_q;
    logic [1:0]          timeout_q;

    logic [31:0]         timer_d;
    logic [1:0]          issue_src_d;
    logic                issue_ch_d;
    logic [1:0]          issue_rest_d;

    // Period timer next value and selection of the next channel to command.
    // The timer only starts counting once link has been seen high for a full
    // cycle, so the first command lands PERIOD+1 cycles after link-up while a
    // back-to-back round lands PERIOD cycles after round_done.
    always_comb begin
        timer_d      = link_seen_q ? timer_q + 32'd1 : 32'd0;
        issue_src_d  = (state_q == WAIT_PERIOD) ? ch_en_i : mask_q;
        issue_ch_d   = ~issue_src_d[0];
        issue_rest_d = issue_src_d;
        issue_rest_d[issue_ch_d] = 1'b0;
    end

    // Scheduler FSM with all outputs registered; link loss overrides every state.
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            state_q      <= WAIT_PERIOD;
            timer_q      <= '0;
            link_seen_q  <= 1'b0;
            mask_q       <= '0;
            ch_q         <= 1'b0;
            pulse_q      <= '0;
            wait_q       <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            round_done_q <= 1'b0;
            timeout_q    <= '0;
        end else begin
            link_seen_q  <= link_ok_i;
            round_done_q <= 1'b0;
            if (!link_ok_i) begin
                state_q <= WAIT_PERIOD;
                timer_q <= '0;
                cmd_q   <= '0;
                pulse_q <= '0;
                wait_q  <= '0;
            end else begin
                case (state_q)
                    WAIT_PERIOD: begin
                        if (timer_q == TIMER_LAST) begin
                            timer_q <= '0;
                            mask_q  <= ch_en_i;
                            if (ch_en_i != 2'b00) begin
                                state_q            <= ISSUE;
                                ch_q               <= issue_ch_d;
                                mask_q             <= issue_rest_d;
                                cmd_q              <= '0;
                                cmd_q[issue_ch_d]  <= 1'b1;
                                addr_q             <= START_ADDR;
                                pulse_q            <= '0;
                            end
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                    ISSUE: begin
                        if (pulse_q == PULSE_LAST) begin
                            cmd_q   <= '0;
                            wait_q  <= '0;
                            state_q <= WAIT_DONE;
                        end else begin
                            pulse_q <= pulse_q + PW'(1);
                        end
                    end
                    WAIT_DONE: begin
                        if (!busy_i[ch_q]) begin
                            state_q <= NEXT;
                        end else if (wait_q == WAIT_LAST) begin
                            timeout_q[ch_q] <= 1'b1;
                            state_q         <= NEXT;
                        end else begin
                            wait_q <= wait_q + WW'(1);
                        end
                    end
                    NEXT: begin
                        if (mask_q != 2'b00) begin
                            state_q            <= ISSUE;
                            ch_q               <= issue_ch_d;
                            mask_q             <= issue_rest_d;
                            cmd_q              <= '0;
                            cmd_q[issue_ch_d]  <= 1'b1;
                            addr_q             <= START_ADDR;
                            pulse_q            <= '0;
                        end else begin
                            round_done_q <= 1'b1;
                            timer_q      <= '0;
                            state_q      <= WAIT_PERIOD;
                        end
                    end
                    default: begin
                        state_q <= WAIT_PERIOD;
                        timer_q <= '0;
                        cmd_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign start_ram_addr_o = addr_q;
    assign cmd_send_o       = cmd_q;
    assign active_ch_o      = ch_q;
    assign round_done_o     = round_done_q;
    assign timeout_o        = timeout_q;

`ifdef SCHED_STATS_EN
    // A send counts as completed when busy drops inside the wait window.
    logic send_ok_d;
    assign send_ok_d = link_ok_i && (state_q == WAIT_DONE) && !busy_i[ch_q];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic [15:0] send_cnt_q;
            // Saturating per-channel completed-send counter.
            always_ff @(posedge clk_50_pll or posedge main_reset) begin
                if (main_reset) begin
                    send_cnt_q <= '0;
                end else if (send_ok_d && (ch_q == 1'(gi)) && (send_cnt_q != 16'hFFFF)) begin
                    send_cnt_q <= send_cnt_q + 16'd1;
                end
            end
        end
    endgenerate

    assign send_cnt_1_o = g_stats[0].send_cnt_q;
    assign send_cnt_2_o = g_stats[1].send_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
